// File: rtl/regfile_param.sv
// regfile_param: parameterised register file with optional write-to-read
// bypass, optional hard-wired zero register, a per-register pending
// scoreboard, a conditional bit and a sequential bulk-clear engine.
module regfile_param #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 3,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              write_i,
    input  logic [ADDR_W-1:0] write_addr_i,
    input  logic [DATA_W-1:0] write_data_i,
    input  logic              write_CB_i,
    input  logic              cb_data_i,
    output logic              cb_data_o,
    input  logic [ADDR_W-1:0] rs_addr_i,
    input  logic [ADDR_W-1:0] rt_addr_i,
    output logic [DATA_W-1:0] rs_data_o,
    output logic [DATA_W-1:0] rt_data_o,
    input  logic              reserve_i,
    input  logic [ADDR_W-1:0] reserve_addr_i,
    output logic              rs_busy_o,
    output logic              rt_busy_o,
    input  logic              clear_i,
    output logic              clear_busy_o
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q;
    logic [DATA_W-1:0]   regs_q [DEPTH];
    logic [DEPTH-1:0]    pending_q;
    logic                cb_q;

    logic                idle;
    logic                last_clear;
    logic                wr_en;
    logic                rsv_en;
    logic                rs_fwd;
    logic                rt_fwd;

    assign idle       = (state_q == IDLE);
    assign last_clear = (cnt_q == ADDR_W'(DEPTH - 1));
    assign wr_en      = write_i && idle &&
                        !((ZERO_REG != 0) && (write_addr_i == '0));
    assign rsv_en     = reserve_i && idle &&
                        !((ZERO_REG != 0) && (reserve_addr_i == '0));
    assign rs_fwd     = (BYPASS != 0) && wr_en && (write_addr_i == rs_addr_i);
    assign rt_fwd     = (BYPASS != 0) && wr_en && (write_addr_i == rt_addr_i);

    // Next-state logic: enter CLEAR on request, leave after the last index
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (clear_i) state_d = CLEAR;
            CLEAR:   if (last_clear) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register and clear index counter
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == CLEAR) cnt_q <= cnt_q + ADDR_W'(1);
            else                  cnt_q <= '0;
        end
    end

    // Register array: normal writes in IDLE, one entry zeroed per cycle in CLEAR
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) regs_q[i] <= '0;
        end else if (state_q == CLEAR) begin
            regs_q[cnt_q] <= '0;
        end else if (wr_en) begin
            regs_q[write_addr_i] <= write_data_i;
        end
    end

    // Scoreboard: reserve is applied after the write-clear so it wins on a tie
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending_q <= '0;
        end else if (state_q == CLEAR) begin
            pending_q[cnt_q] <= 1'b0;
        end else begin
            if (wr_en)  pending_q[write_addr_i]   <= 1'b0;
            if (rsv_en) pending_q[reserve_addr_i] <= 1'b1;
        end
    end

    // Conditional bit: loads in IDLE, forced to zero when a clear starts
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cb_q <= 1'b0;
        end else if (idle) begin
            if (clear_i)         cb_q <= 1'b0;
            else if (write_CB_i) cb_q <= cb_data_i;
        end
    end

    // Read ports with optional forwarding and zero-register masking
    always_comb begin
        rs_data_o = regs_q[rs_addr_i];
        rt_data_o = regs_q[rt_addr_i];
        rs_busy_o = pending_q[rs_addr_i];
        rt_busy_o = pending_q[rt_addr_i];
        if (rs_fwd) begin
            rs_data_o = write_data_i;
            rs_busy_o = 1'b0;
        end
        if (rt_fwd) begin
            rt_data_o = write_data_i;
            rt_busy_o = 1'b0;
        end
        if ((ZERO_REG != 0) && (rs_addr_i == '0)) begin
            rs_data_o = '0;
            rs_busy_o = 1'b0;
        end
        if ((ZERO_REG != 0) && (rt_addr_i == '0)) begin
            rt_data_o = '0;
            rt_busy_o = 1'b0;
        end
    end

    assign cb_data_o    = cb_q;
    assign clear_busy_o = (state_q == CLEAR);

endmodule

// File: tb/tb_regfile_param.sv
// tb_regfile_param: drives two configurations of regfile_param with shared
// stimulus and compares every output against an array-based reference model.
//   u0: DATA_W=8,  ADDR_W=3, BYPASS=1, ZERO_REG=0
//   u1: DATA_W=16, ADDR_W=4, BYPASS=0, ZERO_REG=1
module tb_regfile_param;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr, wcb, cbd, res, clr;
    logic [3:0]  wa, rs, rt, ra;
    logic [15:0] wd;

    logic        cb0, rsb0, rtb0, cbusy0;
    logic [7:0]  rsd0, rtd0;
    logic        cb1, rsb1, rtb1, cbusy1;
    logic [15:0] rsd1, rtd1;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    logic [15:0] m_mem  [2][16];
    logic        m_pend [2][16];
    logic        m_cb   [2];
    int          m_cidx [2];   // -1 when idle, else next index to clear

    int          dep  [2] = '{8, 16};
    logic [15:0] mask [2] = '{16'h00FF, 16'hFFFF};
    bit          byp  [2] = '{1'b1, 1'b0};
    bit          zr   [2] = '{1'b0, 1'b1};

    always #5 clk = ~clk;

    regfile_param #(.DATA_W(8), .ADDR_W(3), .BYPASS(1), .ZERO_REG(0)) u0 (
        .clk_i(clk), .rst_ni(rst_n),
        .write_i(wr), .write_addr_i(wa[2:0]), .write_data_i(wd[7:0]),
        .write_CB_i(wcb), .cb_data_i(cbd), .cb_data_o(cb0),
        .rs_addr_i(rs[2:0]), .rt_addr_i(rt[2:0]),
        .rs_data_o(rsd0), .rt_data_o(rtd0),
        .reserve_i(res), .reserve_addr_i(ra[2:0]),
        .rs_busy_o(rsb0), .rt_busy_o(rtb0),
        .clear_i(clr), .clear_busy_o(cbusy0)
    );

    regfile_param #(.DATA_W(16), .ADDR_W(4), .BYPASS(0), .ZERO_REG(1)) u1 (
        .clk_i(clk), .rst_ni(rst_n),
        .write_i(wr), .write_addr_i(wa), .write_data_i(wd),
        .write_CB_i(wcb), .cb_data_i(cbd), .cb_data_o(cb1),
        .rs_addr_i(rs), .rt_addr_i(rt),
        .rs_data_o(rsd1), .rt_data_o(rtd1),
        .reserve_i(res), .reserve_addr_i(ra),
        .rs_busy_o(rsb1), .rt_busy_o(rtb1),
        .clear_i(clr), .clear_busy_o(cbusy1)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp_rd(int k, logic [3:0] a);
        int ai = int'(a) % dep[k];
        int wi = int'(wa) % dep[k];
        if (zr[k] && ai == 0) return 16'h0;
        if (byp[k] && m_cidx[k] < 0 && wr && wi == ai) return wd & mask[k];
        return m_mem[k][ai];
    endfunction

    function automatic logic exp_busy(int k, logic [3:0] a);
        int ai = int'(a) % dep[k];
        int wi = int'(wa) % dep[k];
        if (zr[k] && ai == 0) return 1'b0;
        if (byp[k] && m_cidx[k] < 0 && wr && wi == ai) return 1'b0;
        return m_pend[k][ai];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 16; i++) begin
                m_mem[k][i]  = 16'h0;
                m_pend[k][i] = 1'b0;
            end
            m_cb[k]   = 1'b0;
            m_cidx[k] = -1;
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            int wi = int'(wa) % dep[k];
            int ri = int'(ra) % dep[k];
            if (m_cidx[k] < 0) begin
                if (wr && !(zr[k] && wi == 0)) begin
                    m_mem[k][wi]  = wd & mask[k];
                    m_pend[k][wi] = 1'b0;
                end
                if (res && !(zr[k] && ri == 0)) m_pend[k][ri] = 1'b1;
                if (wcb) m_cb[k] = cbd;
                if (clr) begin
                    m_cidx[k] = 0;
                    m_cb[k]   = 1'b0;
                end
            end else begin
                m_mem[k][m_cidx[k]]  = 16'h0;
                m_pend[k][m_cidx[k]] = 1'b0;
                m_cidx[k]++;
                if (m_cidx[k] == dep[k]) m_cidx[k] = -1;
            end
        end
    endtask

    task automatic check_outputs();
        check("u0.rs_data", {8'h0, rsd0}, exp_rd(0, rs));
        check("u0.rt_data", {8'h0, rtd0}, exp_rd(0, rt));
        check("u0.rs_busy", {15'h0, rsb0}, {15'h0, exp_busy(0, rs)});
        check("u0.rt_busy", {15'h0, rtb0}, {15'h0, exp_busy(0, rt)});
        check("u0.cb", {15'h0, cb0}, {15'h0, m_cb[0]});
        check("u0.clear_busy", {15'h0, cbusy0}, {15'h0, m_cidx[0] >= 0});
        check("u1.rs_data", rsd1, exp_rd(1, rs));
        check("u1.rt_data", rtd1, exp_rd(1, rt));
        check("u1.rs_busy", {15'h0, rsb1}, {15'h0, exp_busy(1, rs)});
        check("u1.rt_busy", {15'h0, rtb1}, {15'h0, exp_busy(1, rt)});
        check("u1.cb", {15'h0, cb1}, {15'h0, m_cb[1]});
        check("u1.clear_busy", {15'h0, cbusy1}, {15'h0, m_cidx[1] >= 0});
    endtask

    // called at a negedge with inputs already set; returns at the next negedge
    task automatic step();
        #1;
        check_outputs();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        wr = 1'b0; wcb = 1'b0; cbd = 1'b0; res = 1'b0; clr = 1'b0;
        wa = 4'h0; wd = 16'h0; ra = 4'h0;
    endtask

    // asynchronous reset pulse placed between clock edges
    task automatic pulse_reset();
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs();
        #2;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int n0, n1;
        idle_inputs();
        rs = 4'h0; rt = 4'h0;
        rst_n = 1'b0;
        model_reset();
        #12;
        check_outputs();
        rst_n = 1'b1;
        @(negedge clk);

        // write A5 to r3 with same-cycle and next-cycle reads
        wr = 1'b1; wa = 4'd3; wd = 16'hA5A5; rs = 4'd3; rt = 4'd3;
        step();
        wr = 1'b0;
        step();

        // zero register: write and reserve r0
        wr = 1'b1; wa = 4'd0; wd = 16'hFFFF; res = 1'b1; ra = 4'd0; rs = 4'd0; rt = 4'd0;
        step();
        wr = 1'b0; res = 1'b0;
        step();

        // scoreboard on r5
        res = 1'b1; ra = 4'd5; rt = 4'd5; rs = 4'd5;
        step();
        res = 1'b0;
        step();
        wr = 1'b1; wa = 4'd5; wd = 16'h0F0F;
        step();
        wr = 1'b0;
        step();
        wr = 1'b1; res = 1'b1;
        step();
        wr = 1'b0; res = 1'b0;
        step();

        // fill, set CB, then a single clear pulse with writes attempted throughout
        for (int a = 0; a < 16; a++) begin
            wr = 1'b1; wa = 4'(a); wd = 16'h1111;
            step();
        end
        wr = 1'b0; wcb = 1'b1; cbd = 1'b1;
        step();
        wcb = 1'b0; clr = 1'b1;
        step();
        clr = 1'b0; n0 = 0; n1 = 0;
        for (int i = 0; i < 20; i++) begin
            wr = 1'b1; wa = 4'($urandom_range(15)); wd = 16'($urandom);
            wcb = 1'b1; cbd = 1'b1; rs = 4'($urandom_range(15)); rt = 4'(i % 16);
            if (cbusy0) n0++;
            if (cbusy1) n1++;
            if (i == 15) begin wr = 1'b0; wcb = 1'b0; end
            step();
        end
        check("u0.clear_cycles", 16'(n0), 16'd8);
        check("u1.clear_cycles", 16'(n1), 16'd16);
        idle_inputs();

        // clear_i held in the last CLEAR cycle of u0 must not restart it
        clr = 1'b1;
        step();
        clr = 1'b0;
        for (int i = 0; i < 10; i++) begin
            clr = (i == 7);
            rs = 4'(i); rt = 4'(15 - i);
            step();
        end
        idle_inputs();
        for (int i = 0; i < 10; i++) step();

        // reset in the middle of a clear at cnt=4, then a normal write
        for (int a = 0; a < 16; a++) begin
            wr = 1'b1; wa = 4'(a); wd = 16'hBEEF; res = 1'b1; ra = 4'(a);
            step();
        end
        wr = 1'b0; res = 1'b0; clr = 1'b1;
        step();
        clr = 1'b0; rs = 4'd6; rt = 4'd15;
        for (int i = 0; i < 4; i++) step();
        pulse_reset();
        wr = 1'b1; wa = 4'd15; wd = 16'hBEEF; rs = 4'd2; rt = 4'd15;
        step();
        wr = 1'b0; rs = 4'd7;
        step();

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            wr  = ($urandom_range(1) == 1);
            wa  = 4'($urandom_range(15));
            wd  = 16'($urandom);
            wcb = ($urandom_range(3) == 0);
            cbd = ($urandom_range(1) == 1);
            res = ($urandom_range(2) == 0);
            ra  = ($urandom_range(3) == 0) ? wa : 4'($urandom_range(15));
            rs  = ($urandom_range(2) == 0) ? wa : 4'($urandom_range(15));
            rt  = ($urandom_range(3) == 0) ? ra : 4'($urandom_range(15));
            clr = ($urandom_range(39) == 0);
            if (i == 900) begin
                pulse_reset();
            end else begin
                step();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
